memory_access_stage: RTL and testbench

- MEM-stage data-memory access unit; sits between the execute/memory pipeline register and writeback_pipeline_reg.
- Converts load/store control from the M stage into a request/ready transaction on a variable-latency data-memory port.
- Holds the pipeline with StallM until the transaction completes, then presents ReadDataM to the writeback register.
- Flags misaligned accesses and bus timeouts to the hazard/exception logic.

---
 rtl/memory_access_stage_pkg.sv | 22 ++
 rtl/memory_access_stage_timeout_counter.sv | 27 ++
 rtl/memory_access_stage.sv | 118 +++++++++++
 tb/tb_memory_access_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_stage_pkg.sv
// Shared types and defaults for the MEM-stage data-memory access unit.
package memory_access_stage_pkg;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int unsigned DEFAULT_CNT_WIDTH      = 16;
    localparam int unsigned ADDR_W                 = 32;
    localparam int unsigned DATA_W                 = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mas_state_e;

    // Request payload latched at the start of a transaction
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/memory_access_stage_timeout_counter.sv
// Counts REQ-state cycles without mem_ready; expired_c flags the last permitted cycle.
module mem_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

    assign expired_c = (count == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/memory_access_stage.sv
// MEM-stage load/store unit: drives a request/ready data-memory port and stalls
// the pipeline until the access completes or times out.
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned CNT_WIDTH      = DEFAULT_CNT_WIDTH
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              MemtoRegM,
    input  logic              MemWriteM,
    input  logic [ADDR_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              StallM,
    output logic              MisalignM,
    output logic              BusErrM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    mas_state_e        state_q, state_d;
    mem_cmd_t          cmd_q, cmd_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              berr_q, berr_d;
    logic              mem_op, access;
    logic              cnt_clear, cnt_en, expired;

    assign mem_op    = MemtoRegM | MemWriteM;
    assign access    = mem_op & (ALUOutM[1:0] == 2'b00);
    assign MisalignM = mem_op & (ALUOutM[1:0] != 2'b00);

    mem_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_WIDTH     (CNT_WIDTH)
    ) u_timeout (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .expired_c(expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            req_q   <= 1'b0;
            rdata_q <= '0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            berr_q  <= berr_d;
        end
    end

    // Next state, next register values and the combinational stall
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        req_d     = req_q;
        rdata_d   = rdata_q;
        berr_d    = 1'b0;
        StallM    = 1'b0;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                StallM = access;
                if (access) begin
                    state_d   = ST_REQ;
                    req_d     = 1'b1;
                    cmd_d     = '{we: MemWriteM, addr: ALUOutM, wdata: WriteDataM};
                    cnt_clear = 1'b1;
                end
            end
            ST_REQ: begin
                StallM = 1'b1;
                // Completion takes priority over a timeout in the same cycle
                if (mem_ready) begin
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                    if (!cmd_q.we) begin
                        rdata_d = mem_rdata;
                    end
                end else if (expired) begin
                    req_d   = 1'b0;
                    rdata_d = '0;
                    berr_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            // Inputs here still belong to the finished instruction; never re-issue
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_req   = req_q;
    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign ReadDataM = rdata_q;
    assign BusErrM   = berr_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage with a latency-programmable memory responder.
module tb_memory_access_stage;

    localparam int unsigned TMO = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        MemtoRegM, MemWriteM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, MisalignM, BusErrM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    always #5 clock = ~clock;

    memory_access_stage #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(16)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .MemtoRegM (MemtoRegM),
        .MemWriteM (MemWriteM),
        .ALUOutM   (ALUOutM),
        .WriteDataM(WriteDataM),
        .ReadDataM (ReadDataM),
        .StallM    (StallM),
        .MisalignM (MisalignM),
        .BusErrM   (BusErrM),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        bit          mis;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          berr;
        int          stalls;
    } exp_t;

    exp_t        exp_q[$];
    int          lat_q[$];
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] bus_mem [logic [31:0]];
    logic [31:0] rd_model = 32'h0;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: answers after the latency the stimulus chose; random ready noise when idle
    int req_cnt = 0;
    int cur_lat = 0;
    always @(negedge clock) begin
        if (mem_req === 1'b1) begin
            if (req_cnt == 0) cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1000;
            req_cnt++;
            if (req_cnt == cur_lat + 1) begin
                mem_ready = 1'b1;
                if (mem_we) begin
                    bus_mem[mem_addr] = mem_wdata;
                    mem_rdata = $urandom();
                end else begin
                    mem_rdata = bus_mem.exists(mem_addr) ? bus_mem[mem_addr] : init_val(mem_addr);
                end
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom();
            end
        end else begin
            req_cnt   = 0;
            mem_ready = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom();
        end
    end

    // Monitor: pops an expectation whenever the DUT stalls or flags a misalignment
    bit   in_txn = 1'b0;
    int   stall_cnt = 0;
    exp_t cur;
    always @(negedge clock) begin
        if (!mon_en) begin
            in_txn    = 1'b0;
            stall_cnt = 0;
        end else if (in_txn) begin
            if (StallM === 1'b1) begin
                stall_cnt++;
                if (mem_req === 1'b1) begin
                    check("mem_we", 32'(mem_we), 32'(cur.we));
                    check("mem_addr", mem_addr, cur.addr);
                    check("mem_wdata", mem_wdata, cur.wdata);
                end
                if (stall_cnt > 40) begin
                    check("stall_bound", 32'(stall_cnt), 32'(cur.stalls));
                    in_txn = 1'b0;
                end
            end else begin
                check("stall_cycles", 32'(stall_cnt), 32'(cur.stalls));
                check("read_data", ReadDataM, cur.rdata);
                check("bus_err", 32'(BusErrM), 32'(cur.berr));
                check("req_done", 32'(mem_req), 32'h0);
                in_txn = 1'b0;
            end
        end else if (StallM === 1'b1 || MisalignM === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_stall_or_misalign", 32'({StallM, MisalignM}), 32'h0);
            end else begin
                cur = exp_q.pop_front();
                check("stall_start", 32'(StallM), 32'(!cur.mis));
                check("misalign", 32'(MisalignM), 32'(cur.mis));
                check("req_idle", 32'(mem_req), 32'h0);
                check("buserr_idle", 32'(BusErrM), 32'h0);
                if (cur.mis) begin
                    check("read_data_misaligned", ReadDataM, cur.rdata);
                end else begin
                    in_txn    = 1'b1;
                    stall_cnt = 1;
                end
            end
        end else begin
            check("idle_req", 32'(mem_req), 32'h0);
            check("idle_buserr", 32'(BusErrM), 32'h0);
        end
    end

    // Present one M-stage instruction and hold it until the pipeline advances
    task automatic issue(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                         input int lat);
        exp_t e;
        int   reqc;
        bit   tmo;
        int   n;
        MemtoRegM  = (kind == 1);
        MemWriteM  = (kind == 2);
        ALUOutM    = addr;
        WriteDataM = wdata;
        if (kind != 0) begin
            e.mis   = (addr[1:0] != 2'b00);
            e.we    = (kind == 2);
            e.addr  = addr;
            e.wdata = wdata;
            if (e.mis) begin
                e.rdata  = rd_model;
                e.berr   = 1'b0;
                e.stalls = 0;
            end else begin
                tmo      = (lat + 1 > int'(TMO));
                reqc     = tmo ? int'(TMO) : lat + 1;
                e.stalls = 1 + reqc;
                e.berr   = tmo;
                if (tmo) rd_model = 32'h0;
                else if (kind == 1) rd_model = ref_mem.exists(addr) ? ref_mem[addr] : init_val(addr);
                else ref_mem[addr] = wdata;
                e.rdata = rd_model;
                lat_q.push_back(lat);
            end
            exp_q.push_back(e);
        end
        n = 0;
        @(negedge clock);
        while (StallM === 1'b1 && n < 30) begin
            n++;
            @(negedge clock);
        end
        if (n >= 30) check("advance_timeout", 32'(n), 32'h0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          k;
        int          n;
        logic [31:0] a;
        reset_n    = 1'b0;
        MemtoRegM  = 1'b0;
        MemWriteM  = 1'b0;
        ALUOutM    = 32'h0;
        WriteDataM = 32'h0;
        repeat (3) @(negedge clock);
        check("rst_req", 32'(mem_req), 32'h0);
        check("rst_we", 32'(mem_we), 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_rdata", ReadDataM, 32'h0);
        check("rst_buserr", 32'(BusErrM), 32'h0);
        check("rst_stall", 32'(StallM), 32'h0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        mon_en = 1'b1;

        issue(2, 32'h100, 32'hCAFE_BABE, 0);
        issue(1, 32'h100, 32'h1111_1111, 2);
        issue(2, 32'h20, 32'h1234_5678, 0);
        issue(1, 32'h200, 32'h0, 9);
        issue(1, 32'h20, 32'h0, 3);
        issue(1, 32'h102, 32'h0, 0);
        issue(2, 32'h103, 32'hDEAD_BEEF, 0);
        issue(0, 32'h0, 32'h0, 0);
        issue(0, 32'h44, 32'h0, 0);

        for (int i = 0; i < 250; i++) begin
            k = $urandom_range(0, 9);
            a = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
            if (k < 2)      issue(0, a, $urandom(), 0);
            else if (k < 6) issue(1, a, $urandom(), $urandom_range(0, 6));
            else if (k < 9) issue(2, a, $urandom(), $urandom_range(0, 6));
            else            issue($urandom_range(1, 2), a | 32'($urandom_range(1, 3)), $urandom(), 0);
        end
        issue(0, 32'h0, 32'h0, 0);
        repeat (2) @(negedge clock);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        // Reset in the middle of an outstanding request
        mon_en    = 1'b0;
        MemtoRegM = 1'b1;
        MemWriteM = 1'b0;
        ALUOutM   = 32'h300;
        lat_q.push_back(50);
        n = 0;
        @(negedge clock);
        while (mem_req !== 1'b1 && n < 10) begin
            n++;
            @(negedge clock);
        end
        check("midreq_seen", 32'(mem_req), 32'h1);
        reset_n   = 1'b0;
        MemtoRegM = 1'b0;
        #1;
        check("midrst_req", 32'(mem_req), 32'h0);
        check("midrst_rdata", ReadDataM, 32'h0);
        check("midrst_buserr", 32'(BusErrM), 32'h0);
        check("midrst_stall", 32'(StallM), 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        lat_q.delete();
        exp_q.delete();
        rd_model = 32'h0;
        @(negedge clock);
        check("post_rst_stall", 32'(StallM), 32'h0);
        check("post_rst_req", 32'(mem_req), 32'h0);
        @(posedge clock);
        #1;
        mon_en = 1'b1;
        issue(1, 32'h100, 32'h0, 1);
        issue(0, 32'h0, 32'h0, 0);
        repeat (2) @(negedge clock);
        check("final_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
